// File: rtl/cpu_ctrl_unit.sv
// cpu_ctrl_unit: fetch/decode/execute sequencer for the tiny RISC CPU with memory-ready timeout, halt/resume and retire counter
module cpu_ctrl_unit #(
   parameter int OPW     = 2,
   parameter int TIMEOUT = 15,
   parameter int TOW     = 4,
   parameter int CNTW    = 8
) (
   input  logic            clk_i,
   input  logic            clr_n_i,
   input  logic            start_i,
   input  logic            halt_req_i,
   input  logic [OPW-1:0]  opcode_i,
   input  logic            mem_rdy_i,
   output logic            pc_clr_o,
   output logic            pc_inc_o,
   output logic            pc_load_o,
   output logic            ar_load_o,
   output logic            ar_sel_o,
   output logic            mem_rd_o,
   output logic            dr_load_o,
   output logic            ir_load_o,
   output logic            ac_load_o,
   output logic [1:0]      alu_op_o,
   output logic [3:0]      state_o,
   output logic            fault_o,
   output logic [CNTW-1:0] instr_cnt_o
);
   typedef enum logic [3:0] {
      IDLE = 4'd0, F1 = 4'd1, F2 = 4'd2, F3 = 4'd3, DEC = 4'd4, ADD1 = 4'd5, ADD2 = 4'd6,
      AND1 = 4'd7, AND2 = 4'd8, JMP1 = 4'd9, INC1 = 4'd10, HALT = 4'd11, FAULT = 4'd12
   } state_e;
   localparam logic [TOW-1:0] WAIT_LAST = TOW'(TIMEOUT - 1);
   state_e state_q, state_d;
   logic [TOW-1:0] wait_q, wait_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic mem_st, retire, timeout, start_ok;
   assign mem_st   = state_q inside {F2, ADD1, AND1};
   assign retire   = state_q inside {ADD2, AND2, JMP1, INC1};
   assign timeout  = (TIMEOUT != 0) && !mem_rdy_i && (wait_q == WAIT_LAST);
   assign start_ok = start_i && clr_n_i;
   assign wait_d   = (mem_st && !mem_rdy_i && state_d == state_q) ? wait_q + 1'b1 : '0;
   assign cnt_d    = retire ? cnt_q + 1'b1 : cnt_q;
   assign state_o     = state_q;
   assign instr_cnt_o = cnt_q;
   // state, wait counter and retire counter registers; reset aborts any instruction at once
   always_ff @(posedge clk_i or negedge clr_n_i) begin
      if (!clr_n_i) begin
         state_q <= IDLE;
         wait_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cnt_q   <= cnt_d;
      end
   end
   // next-state: memory states wait for mem_rdy, falling to FAULT when the wait budget runs out
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:                   state_d = start_i ? F1 : IDLE;
         F1:                     state_d = halt_req_i ? HALT : F2;
         F2:                     state_d = mem_rdy_i ? F3 : timeout ? FAULT : F2;
         F3:                     state_d = DEC;
         DEC:                    state_d = (opcode_i == OPW'(0)) ? ADD1 :
                                           (opcode_i == OPW'(1)) ? AND1 :
                                           (opcode_i == OPW'(2)) ? JMP1 : INC1;
         ADD1:                   state_d = mem_rdy_i ? ADD2 : timeout ? FAULT : ADD1;
         AND1:                   state_d = mem_rdy_i ? AND2 : timeout ? FAULT : AND1;
         ADD2, AND2, JMP1, INC1: state_d = F1;
         HALT:                   state_d = start_i ? F1 : HALT;
         FAULT:                  state_d = start_i ? F1 : FAULT;
         default:                state_d = IDLE;
      endcase
   end
   // datapath strobes decoded from the current state; pc_clr is masked while reset is held
   always_comb begin
      pc_clr_o  = 1'b0;
      pc_inc_o  = 1'b0;
      pc_load_o = 1'b0;
      ar_load_o = 1'b0;
      ar_sel_o  = 1'b0;
      mem_rd_o  = 1'b0;
      dr_load_o = 1'b0;
      ir_load_o = 1'b0;
      ac_load_o = 1'b0;
      alu_op_o  = 2'b00;
      fault_o   = 1'b0;
      case (state_q)
         IDLE:       pc_clr_o = start_ok;
         F1:         ar_load_o = !halt_req_i;
         F2: begin
            mem_rd_o  = 1'b1;
            dr_load_o = mem_rdy_i;
            pc_inc_o  = mem_rdy_i;
         end
         F3: begin
            ir_load_o = 1'b1;
            ar_load_o = 1'b1;
            ar_sel_o  = 1'b1;
         end
         ADD1, AND1: begin
            mem_rd_o  = 1'b1;
            dr_load_o = mem_rdy_i;
         end
         ADD2:       ac_load_o = 1'b1;
         AND2: begin
            ac_load_o = 1'b1;
            alu_op_o  = 2'b01;
         end
         JMP1:       pc_load_o = 1'b1;
         INC1: begin
            ac_load_o = 1'b1;
            alu_op_o  = 2'b10;
         end
         FAULT: begin
            fault_o  = 1'b1;
            pc_clr_o = start_ok;
         end
         default: ;
      endcase
   end
endmodule
